// File: rtl/conv_inst_loop_rx_pkg.sv
// Shared definitions for the looped-instruction receive path.
package conv_inst_loop_rx_pkg;

  localparam int unsigned IRW_DEF    = 30;
  localparam int unsigned IN_DEF     = 3;
  localparam int unsigned LOOP_N_DEF = 10;
  localparam int unsigned FC_BIT     = 0;
  localparam int unsigned ITER_W     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOOP = 1'b1
  } loop_state_e;

endpackage

// File: rtl/conv_skid_buf.sv
// Two-entry skid buffer with registered ready/valid on both sides.
module conv_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic [W-1:0] skid_q;
  logic         push_c;
  logic         pop_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push_c && !pop_c)      cnt_d = cnt_q + 2'd1;
    else if (pop_c && !push_c) cnt_d = cnt_q - 2'd1;
  end

  // out_data is the head entry; skid_q only holds a second beat while the head is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      in_ready  <= (cnt_d != 2'd2);
      out_valid <= (cnt_d != 2'd0);
      if (pop_c && (cnt_q == 2'd2))                 out_data <= skid_q;
      else if (push_c && ((cnt_q == 2'd0) || pop_c)) out_data <= in_data;
      if (push_c && !pop_c && (cnt_q == 2'd1))      skid_q   <= in_data;
    end
  end

endmodule

// File: rtl/conv_inst_loop_rx.sv
// Receives fc-looped instruction beats, tags iteration/last, checks loop consistency.
module conv_inst_loop_rx
  import conv_inst_loop_rx_pkg::*;
#(
  parameter int unsigned IRW    = IRW_DEF,
  parameter int unsigned IN     = IN_DEF,
  parameter int unsigned LOOP_N = LOOP_N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRW*IN-1:0]   m_inst,
  input  logic                m_valid,
  output logic                m_ready,
  output logic [IRW*IN-1:0]   s_inst,
  output logic [ITER_W-1:0]   s_iter,
  output logic                s_last,
  output logic                s_valid,
  input  logic                s_ready,
  output logic                err,
  input  logic                clr_err
);

  localparam int unsigned DW = IRW * IN;
  localparam int unsigned BW = DW + ITER_W + 1;

  loop_state_e       state_q;
  logic [ITER_W-1:0] cnt_q;
  logic [DW-1:0]     ref_q;
  logic              accept_c;
  logic [ITER_W-1:0] iter_c;
  logic              last_c;
  logic              mismatch_c;
  logic [BW-1:0]     buf_out;

  assign accept_c = m_valid & m_ready;

  // Tag for the beat presented now; inside a loop the fc bit is only part of the compare
  always_comb begin
    iter_c     = '0;
    last_c     = ~m_inst[FC_BIT];
    mismatch_c = 1'b0;
    if (state_q == ST_LOOP) begin
      iter_c     = cnt_q;
      last_c     = (cnt_q == ITER_W'(LOOP_N - 1));
      mismatch_c = accept_c & (m_inst != ref_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      err     <= 1'b0;
    end else begin
      if (mismatch_c)   err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (accept_c) begin
        if (state_q == ST_IDLE) begin
          if (m_inst[FC_BIT]) begin
            ref_q   <= m_inst;
            cnt_q   <= ITER_W'(1);
            state_q <= ST_LOOP;
          end
        end else if (last_c) begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          cnt_q <= cnt_q + ITER_W'(1);
        end
      end
    end
  end

  conv_skid_buf #(
    .W (BW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({m_inst, iter_c, last_c}),
    .in_valid  (m_valid),
    .in_ready  (m_ready),
    .out_data  (buf_out),
    .out_valid (s_valid),
    .out_ready (s_ready)
  );

  assign {s_inst, s_iter, s_last} = buf_out;

endmodule
